// File: rtl/ahb_lite_master_mux.sv
// ahb_lite_master_mux: two-master AHB-lite arbiter and multiplexer. A losing request is
// parked in a per-master hold register and that master is stalled via its HREADY_Mx.
module ahb_lite_master_mux #(
  parameter int HIGH_PRIO = 0,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [DW-1:0] HWDATA_M0,
  output logic          HREADY_M0,
  output logic [DW-1:0] HRDATA_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M1,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA
);
  localparam logic HP = 1'(HIGH_PRIO);
  logic [AW-1:0] w_addr [2];
  logic [1:0]    w_trans [2];
  logic [2:0]    w_size [2];
  logic [1:0]    w_write;
  logic [1:0]    w_eff [2];
  logic [1:0]    w_req, w_issue, w_rdy;
  logic          w_grant;
  logic [AW-1:0] r_hold_addr [2];
  logic [2:0]    r_hold_size [2];
  logic [1:0]    r_hold_vld, r_hold_write;
  logic          r_addr_owner, r_data_vld, r_data_owner;

  assign w_addr  = '{HADDR_M0, HADDR_M1};
  assign w_trans = '{HTRANS_M0, HTRANS_M1};
  assign w_size  = '{HSIZE_M0, HSIZE_M1};
  assign w_write = {HWRITE_M1, HWRITE_M0};

  // a parked request is replayed as NONSEQ; the live inputs are ignored while held
  always_comb
    for (int k = 0; k < 2; k++) begin
      w_eff[k] = r_hold_vld[k] ? 2'b10 : w_trans[k];
      w_req[k] = HRESETn & (r_hold_vld[k] | w_trans[k][1]);
    end

  // a SEQ beat from the owner keeps the grant; a held request beats a fresh one
  assign w_grant = (!HREADY || w_eff[r_addr_owner] == 2'b11 || w_req == 2'b00) ? r_addr_owner :
                   (&w_req) ? ((^r_hold_vld) ? r_hold_vld[1] : HP) : w_req[1];

  always_comb
    for (int k = 0; k < 2; k++) begin
      w_issue[k] = HREADY & w_req[k] & (w_grant == 1'(k));
      w_rdy[k]   = (r_data_vld && r_data_owner == 1'(k)) ? HREADY : !r_hold_vld[k];
    end

  assign HTRANS    = w_req[w_grant] ? w_eff[w_grant] : 2'b00;
  assign HADDR     = r_hold_vld[w_grant] ? r_hold_addr[w_grant] : w_addr[w_grant];
  assign HWRITE    = r_hold_vld[w_grant] ? r_hold_write[w_grant] : w_write[w_grant];
  assign HSIZE     = r_hold_vld[w_grant] ? r_hold_size[w_grant] : w_size[w_grant];
  assign HWDATA    = r_data_owner ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HREADY_M0 = w_rdy[0];
  assign HREADY_M1 = w_rdy[1];

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_addr_owner <= HP;
      r_data_vld   <= 1'b0;
      r_data_owner <= 1'b0;
      r_hold_vld   <= 2'b00;
      r_hold_write <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_hold_addr[k] <= '0;
        r_hold_size[k] <= '0;
      end
    end else begin
      if (HREADY) begin
        r_addr_owner <= w_grant;
        r_data_vld   <= HTRANS[1];
        if (HTRANS[1]) r_data_owner <= w_grant;
      end
      for (int k = 0; k < 2; k++)
        if (w_issue[k]) r_hold_vld[k] <= 1'b0;
        else if (!r_hold_vld[k] && w_trans[k][1] && w_rdy[k]) begin
          r_hold_vld[k]   <= 1'b1;
          r_hold_addr[k]  <= w_addr[k];
          r_hold_write[k] <= w_write[k];
          r_hold_size[k]  <= w_size[k];
        end
    end
endmodule

// File: tb/tb_ahb_lite_master_mux.sv
// tb_ahb_lite_master_mux: directed scenarios followed by random two-master traffic checked
// against a transaction-level scoreboard (accepted transfers must each reach the bus once, in order).
module tb_ahb_lite_master_mux;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        HCLK, HRESETn;
  logic [31:0] haddr_m [2];
  logic [1:0]  htrans_m [2];
  logic        hwrite_m [2];
  logic [2:0]  hsize_m [2];
  logic [31:0] hwdata_m [2];
  logic        hready_m [2];
  logic [31:0] hrdata_m [2];
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;

  int          checks = 0, errors = 0;
  xfer_t       q [2][$];
  xfer_t       dp, t;
  logic        dp_valid;
  int          dp_own, o, r;
  logic        acc [2];
  logic        exp_rdy;
  logic [31:0] cur_wd [2];
  int          wt [2];

  ahb_lite_master_mux #(.HIGH_PRIO(0), .AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(haddr_m[0]), .HTRANS_M0(htrans_m[0]), .HWRITE_M0(hwrite_m[0]),
    .HSIZE_M0(hsize_m[0]), .HWDATA_M0(hwdata_m[0]), .HREADY_M0(hready_m[0]), .HRDATA_M0(hrdata_m[0]),
    .HADDR_M1(haddr_m[1]), .HTRANS_M1(htrans_m[1]), .HWRITE_M1(hwrite_m[1]),
    .HSIZE_M1(hsize_m[1]), .HWDATA_M1(hwdata_m[1]), .HREADY_M1(hready_m[1]), .HRDATA_M1(hrdata_m[1]),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic drv(input int x, input logic [1:0] tr, input logic [31:0] a, input logic w);
    htrans_m[x] = tr;
    haddr_m[x]  = a;
    hwrite_m[x] = w;
    hsize_m[x]  = 3'b010;
  endtask

  initial begin
    HRESETn = 0; HREADY = 1; HRDATA = 0;
    drv(0, 2'b10, 32'h100, 0); drv(1, 2'b10, 32'h1100, 0);
    hwdata_m[0] = 0; hwdata_m[1] = 0;
    // reset held with both masters requesting
    repeat (3) begin
      smp();
      chk("rst_htrans", 64'(HTRANS), 64'd0);
      chk("rst_rdy0", 64'(hready_m[0]), 64'd1);
      chk("rst_rdy1", 64'(hready_m[1]), 64'd1);
      nxt();
    end
    HRESETn = 1; drv(0, 2'b00, 0, 0); drv(1, 2'b00, 0, 0);
    smp();
    chk("idle_htrans", 64'(HTRANS), 64'd0);
    chk("idle_rdy0", 64'(hready_m[0]), 64'd1);
    chk("idle_rdy1", 64'(hready_m[1]), 64'd1);
    // M0-only read
    nxt(); drv(0, 2'b10, 32'h100, 0);
    smp();
    chk("rd_haddr", 64'(HADDR), 64'h100);
    chk("rd_htrans", 64'(HTRANS), 64'd2);
    chk("rd_hsize", 64'(HSIZE), 64'd2);
    nxt(); drv(0, 2'b00, 0, 0); HRDATA = 32'hDEAD_BEEF;
    smp();
    chk("rd_hrdata", 64'(hrdata_m[0]), 64'hDEAD_BEEF);
    chk("rd_rdy0", 64'(hready_m[0]), 64'd1);
    // simultaneous writes, M0 wins
    nxt(); drv(0, 2'b10, 32'h10, 1); drv(1, 2'b10, 32'h20, 1);
    hwdata_m[0] = 32'hA0A0_A0A0; hwdata_m[1] = 32'hB1B1_B1B1;
    smp();
    chk("sim_addr0", 64'(HADDR), 64'h10);
    chk("sim_write0", 64'(HWRITE), 64'd1);
    chk("sim_rdy1_a", 64'(hready_m[1]), 64'd1);
    nxt(); drv(0, 2'b00, 0, 0); drv(1, 2'b00, 0, 0);
    smp();
    chk("sim_addr1", 64'(HADDR), 64'h20);
    chk("sim_htrans1", 64'(HTRANS), 64'd2);
    chk("sim_rdy1_b", 64'(hready_m[1]), 64'd0);
    chk("sim_hwdata0", 64'(HWDATA), 64'hA0A0_A0A0);
    nxt();
    smp();
    chk("sim_idle", 64'(HTRANS), 64'd0);
    chk("sim_rdy1_c", 64'(hready_m[1]), 64'd1);
    chk("sim_hwdata1", 64'(HWDATA), 64'hB1B1_B1B1);
    // bus wait states during M0 data phase, M1 starts
    nxt(); drv(0, 2'b10, 32'h30, 0);
    smp();
    chk("ws_addr", 64'(HADDR), 64'h30);
    nxt(); drv(0, 2'b00, 0, 0); drv(1, 2'b10, 32'h40, 0); HREADY = 0;
    smp();
    chk("ws_rdy0_a", 64'(hready_m[0]), 64'd0);
    chk("ws_rdy1_a", 64'(hready_m[1]), 64'd1);
    chk("ws_htrans_a", 64'(HTRANS), 64'd0);
    nxt(); drv(1, 2'b00, 0, 0);
    smp();
    chk("ws_rdy1_b", 64'(hready_m[1]), 64'd0);
    chk("ws_htrans_b", 64'(HTRANS), 64'd0);
    nxt(); HREADY = 1;
    smp();
    chk("ws_htrans_c", 64'(HTRANS), 64'd2);
    chk("ws_addr_c", 64'(HADDR), 64'h40);
    chk("ws_rdy0_c", 64'(hready_m[0]), 64'd1);
    chk("ws_rdy1_c", 64'(hready_m[1]), 64'd0);
    nxt(); HREADY = 0;
    smp();
    chk("ws_rdy1_d", 64'(hready_m[1]), 64'd0);
    chk("ws_htrans_d", 64'(HTRANS), 64'd0);
    nxt(); HREADY = 1;
    smp();
    chk("ws_rdy1_e", 64'(hready_m[1]), 64'd1);
    chk("ws_htrans_e", 64'(HTRANS), 64'd0);
    // M1 INCR burst keeps the grant against M0
    nxt(); drv(1, 2'b10, 32'h200, 0);
    smp();
    chk("bu_addr0", 64'(HADDR), 64'h200);
    chk("bu_htrans0", 64'(HTRANS), 64'd2);
    nxt(); drv(1, 2'b11, 32'h204, 0); drv(0, 2'b10, 32'h300, 0);
    smp();
    chk("bu_addr1", 64'(HADDR), 64'h204);
    chk("bu_htrans1", 64'(HTRANS), 64'd3);
    chk("bu_rdy0_1", 64'(hready_m[0]), 64'd1);
    nxt(); drv(1, 2'b11, 32'h208, 0); drv(0, 2'b10, 32'h304, 0);
    smp();
    chk("bu_addr2", 64'(HADDR), 64'h208);
    chk("bu_rdy0_2", 64'(hready_m[0]), 64'd0);
    nxt(); drv(1, 2'b11, 32'h20C, 0);
    smp();
    chk("bu_addr3", 64'(HADDR), 64'h20C);
    chk("bu_htrans3", 64'(HTRANS), 64'd3);
    chk("bu_rdy0_3", 64'(hready_m[0]), 64'd0);
    nxt(); drv(1, 2'b00, 0, 0);
    smp();
    chk("bu_addr_held", 64'(HADDR), 64'h300);
    chk("bu_htrans_held", 64'(HTRANS), 64'd2);
    chk("bu_rdy0_4", 64'(hready_m[0]), 64'd0);
    chk("bu_rdy1_4", 64'(hready_m[1]), 64'd1);
    nxt();
    smp();
    chk("bu_addr_next", 64'(HADDR), 64'h304);
    chk("bu_rdy0_5", 64'(hready_m[0]), 64'd1);
    nxt(); drv(0, 2'b00, 0, 0);
    smp();
    chk("bu_idle", 64'(HTRANS), 64'd0);
    // reset while M1 is held
    nxt(); drv(0, 2'b10, 32'h400, 0); drv(1, 2'b10, 32'h500, 0);
    smp();
    chk("rh_addr0", 64'(HADDR), 64'h400);
    nxt(); drv(0, 2'b00, 0, 0); drv(1, 2'b00, 0, 0);
    smp();
    chk("rh_addr1", 64'(HADDR), 64'h500);
    chk("rh_rdy1_held", 64'(hready_m[1]), 64'd0);
    #1 HRESETn = 0;
    #1;
    chk("rh_async_rdy1", 64'(hready_m[1]), 64'd1);
    chk("rh_async_htrans", 64'(HTRANS), 64'd0);
    nxt(); HRESETn = 1;
    smp();
    chk("rh_rel_htrans", 64'(HTRANS), 64'd0);
    chk("rh_rel_rdy1", 64'(hready_m[1]), 64'd1);
    nxt();
    smp();
    chk("rh_no_issue", 64'(HTRANS), 64'd0);
    // random traffic against the scoreboard
    dp_valid = 0; dp_own = 0;
    for (int x = 0; x < 2; x++) begin
      acc[x] = 0; wt[x] = 0; cur_wd[x] = 0;
    end
    for (int c = 0; c < 900; c++) begin
      nxt();
      for (int x = 0; x < 2; x++) begin
        if (acc[x]) hwdata_m[x] = cur_wd[x];
        if (acc[x] || !htrans_m[x][1]) begin
          r = int'($urandom_range(0, 9));
          htrans_m[x] = (c >= 870 || r < 4) ? ((r == 0) ? 2'b01 : 2'b00) : 2'b10;
          haddr_m[x]  = (32'(x) << 12) | (32'($urandom_range(0, 1023)) << 2);
          hwrite_m[x] = 1'($urandom_range(0, 1));
          hsize_m[x]  = 3'($urandom_range(0, 2));
          cur_wd[x]   = $urandom;
        end
      end
      HREADY = (c >= 870) ? 1'b1 : ($urandom_range(0, 3) != 0);
      HRDATA = $urandom;
      smp();
      for (int x = 0; x < 2; x++) begin
        exp_rdy = (dp_valid && dp_own == x) ? HREADY : (q[x].size() == 0);
        chk("rnd_rdy", 64'(hready_m[x]), 64'(exp_rdy));
      end
      for (int x = 0; x < 2; x++) begin
        acc[x] = htrans_m[x][1] && hready_m[x];
        if (acc[x]) begin
          t.addr = haddr_m[x]; t.write = hwrite_m[x]; t.size = hsize_m[x]; t.wdata = cur_wd[x];
          q[x].push_back(t);
        end
      end
      if (HREADY) begin
        if (dp_valid) begin
          if (dp.write) chk("rnd_hwdata", 64'(HWDATA), 64'(dp.wdata));
          else chk("rnd_hrdata", 64'(hrdata_m[dp_own]), 64'(HRDATA));
          dp_valid = 0;
        end
        if (HTRANS[1]) begin
          o = int'(HADDR[12]);
          checks++;
          assert (q[o].size() != 0) else begin
            errors++;
            $error("FAIL rnd_spurious: observed issue addr=%0h expected no pending transfer", HADDR);
          end
          if (q[o].size() != 0) begin
            chk("rnd_issue", 64'({HADDR, HWRITE, HSIZE}), 64'({q[o][0].addr, q[o][0].write, q[o][0].size}));
            chk("rnd_htrans", 64'(HTRANS), 64'd2);
            dp = q[o].pop_front();
            dp_own = o;
            dp_valid = 1;
            wt[o] = 0;
          end
        end
        for (int x = 0; x < 2; x++)
          if (q[x].size() != 0) begin
            wt[x]++;
            chk("rnd_wait_bound", 64'(wt[x] <= 2), 64'd1);
          end
      end
    end
    chk("drain_q0", 64'(q[0].size()), 64'd0);
    chk("drain_q1", 64'(q[1].size()), 64'd0);
    chk("drain_dp", 64'(dp_valid), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
